// File: rtl/sorter_pkg.sv
// Shared constants and types for the sorting front end: default frame geometry,
// the loader FSM encoding and the pad value used to push unfilled slots to the
// end of the sorted order.
package sorter_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_N     = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // All-ones pad word at the default width; the loader builds the same value
  // at its own WIDTH so padding always sorts last.
  localparam logic [DEFAULT_WIDTH-1:0] PAD_VALUE = '1;

endpackage

// File: rtl/sort_loader.sv
// sort_loader: collects N words of WIDTH bits into one packed frame for the
// bitonic sorter. FILL accepts words into slot idx; HOLD presents the frame
// until the sorter takes it.
//
// Handshake: a word moves on in_valid & in_ready, and a frame moves on
// out_valid & out_ready. Each side is sampled at the rising edge. in_ready and
// out_valid depend only on the FSM state, never on the opposite handshake.
//
// Optional feature: define SORT_LOADER_PAD_FLUSH_EN to let in_last close a
// short frame. The unused slots are then filled with all-ones, and out_count
// reports the real word count. Without the macro, in_last is ignored.
module sort_loader
  import sorter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = DEFAULT_N
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [N*WIDTH-1:0]     out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(N):0]     out_count,
  output state_t                 dbg_state
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N) + 1;
  localparam logic [WIDTH-1:0] PAD = {WIDTH{1'b1}};

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q;
  logic [N*WIDTH-1:0] data_q;
  logic [CW-1:0]      count_q;

  logic               accept;
  logic               last_slot;
  logic               close;
  logic [CW-1:0]      count_d;

  assign accept    = (state_q == FILL) && in_valid;
  assign last_slot = (idx_q == IW'(N - 1));

`ifdef SORT_LOADER_PAD_FLUSH_EN
  // A word flagged as last closes the frame early. At the final slot this is
  // the same as a normal full frame.
  assign close   = accept && (last_slot || in_last);
  assign count_d = last_slot ? CW'(N) : ({1'b0, idx_q} + CW'(1));
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign close   = accept && last_slot;
  assign count_d = CW'(N);
`endif

  // State register: reset always returns to FILL and drops any pending frame.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // Next-state logic: close a frame into HOLD, release on downstream accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (close)     state_d = HOLD;
      HOLD:    if (out_ready) state_d = FILL;
      default:                state_d = FILL;
    endcase
  end

  // Output decode: the two handshake flags follow the state directly.
  always_comb begin
    in_ready  = (state_q == FILL);
    out_valid = (state_q == HOLD);
    dbg_state = state_q;
  end

  // Slot write, index advance and count capture. The index clears when the
  // frame is released, so slot 0 is next in line.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      if (accept) begin
        data_q[int'(idx_q)*WIDTH +: WIDTH] <= in_data;
        if (close) count_q <= count_d;
        else       idx_q   <= idx_q + IW'(1);
`ifdef SORT_LOADER_PAD_FLUSH_EN
        if (close && !last_slot) begin
          for (int i = 0; i < N; i++) begin
            if (i > int'(idx_q)) data_q[i*WIDTH +: WIDTH] <= PAD;
          end
        end
`endif
      end
      if ((state_q == HOLD) && out_ready) idx_q <= '0;
    end
  end

  assign out_data  = data_q;
  assign out_count = count_q;

endmodule
